// File: rtl/toggle_stim_gen.sv
// Tick-gated four-channel square-wave stimulus source.
// Runs a bounded number of ticks, then pulses done and idles.
module toggle_stim_gen #(
  parameter int HALF_1    = 1,
  parameter int HALF_2    = 2,
  parameter int HALF_3    = 3,
  parameter int HALF_4    = 4,
  parameter int CNT_W     = 8,
  parameter int RUN_TICKS = 16,
  parameter bit IDLE_VAL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic stop,
  input  logic tick,
  output logic out_1,
  output logic out_2,
  output logic out_3,
  output logic out_4,
  output logic busy,
  output logic done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_e;

  // A half-period of 0 behaves like 1.
  localparam int H1 = (HALF_1 < 1) ? 1 : HALF_1;
  localparam int H2 = (HALF_2 < 1) ? 1 : HALF_2;
  localparam int H3 = (HALF_3 < 1) ? 1 : HALF_3;
  localparam int H4 = (HALF_4 < 1) ? 1 : HALF_4;

  localparam logic [CNT_W-1:0] LIM_1 = CNT_W'(H1 - 1);
  localparam logic [CNT_W-1:0] LIM_2 = CNT_W'(H2 - 1);
  localparam logic [CNT_W-1:0] LIM_3 = CNT_W'(H3 - 1);
  localparam logic [CNT_W-1:0] LIM_4 = CNT_W'(H4 - 1);

  localparam logic [15:0] RUN_LAST = 16'(RUN_TICKS - 1);
  localparam logic [3:0]  IDLE_OUTS = {4{IDLE_VAL}};

  state_e                  state_q, state_d;
  logic [3:0][CNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0][CNT_W-1:0]   lim;
  logic [15:0]             run_q, run_d;
  logic [3:0]              out_q, out_d;
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;

  // Index 0 is channel 1.
  assign lim = {LIM_4, LIM_3, LIM_2, LIM_1};

  // State, counters and all outputs are registered here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      run_q   <= '0;
      out_q   <= IDLE_OUTS;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state: start/stop/tick sequencing and per-channel toggles.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    run_d   = run_q;
    out_d   = out_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        out_d  = IDLE_OUTS;
        busy_d = 1'b0;
        if (start) begin
          state_d = S_RUN;
          out_d   = ~IDLE_OUTS;
          cnt_d   = '0;
          run_d   = '0;
          busy_d  = 1'b1;
        end
      end
      S_RUN: begin
        // Abort wins over a tick on the same edge.
        if (stop) begin
          state_d = S_IDLE;
          out_d   = IDLE_OUTS;
          busy_d  = 1'b0;
        end else if (tick) begin
          for (int k = 0; k < 4; k++) begin
            if (cnt_q[k] == lim[k]) begin
              out_d[k] = ~out_q[k];
              cnt_d[k] = '0;
            end else begin
              cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end
          end
          run_d = run_q + 16'd1;
          if (run_q == RUN_LAST) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        out_d   = IDLE_OUTS;
      end
      default: begin
        state_d = S_IDLE;
        out_d   = IDLE_OUTS;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign out_1 = out_q[0];
  assign out_2 = out_q[1];
  assign out_3 = out_q[2];
  assign out_4 = out_q[3];
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_toggle_stim_gen.sv
// Directed bench for toggle_stim_gen with default parameters.
// Vectors are {out_1,out_2,out_3,out_4}, out_1 in the MSB.
module tb_toggle_stim_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic stop;
  logic tick;
  logic out_1, out_2, out_3, out_4;
  logic busy, done;
  logic [3:0] outs;

  int checks = 0;
  int errors = 0;

  toggle_stim_gen dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .stop  (stop),
    .tick  (tick),
    .out_1 (out_1),
    .out_2 (out_2),
    .out_3 (out_3),
    .out_4 (out_4),
    .busy  (busy),
    .done  (done)
  );

  assign outs = {out_1, out_2, out_3, out_4};

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, got, exp);
    end
  endtask

  // Expected levels after n ticks, idle level 1, halves 1..4.
  function automatic logic [3:0] expv(input int n);
    logic [3:0] v;
    v[3] = 1'(((n / 1) % 2) != 0);
    v[2] = 1'(((n / 2) % 2) != 0);
    v[1] = 1'(((n / 3) % 2) != 0);
    v[0] = 1'(((n / 4) % 2) != 0);
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic go();
    start = 1'b1;
    tick  = 1'b1;
    step();
    start = 1'b0;
  endtask

  int dcyc;
  int dcnt;
  int n;

  initial begin
    rst_n = 1'b0;
    start = 1'b1;
    stop  = 1'b0;
    tick  = 1'b0;

    // Reset with start held
    step();
    step();
    chk("rst_outs", outs, 4'b1111);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    start = 1'b0;
    step();
    step();
    chk("idle_outs", outs, 4'b1111);
    chk("idle_busy", busy, 1'b0);

    // Basic run, tick continuous (tick on start edge ignored)
    go();
    chk("run0_outs", outs, 4'b0000);
    chk("run0_busy", busy, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      step();
      chk("run_outs", outs, expv(i));
    end
    chk("t6_outs", outs, 4'b0101);
    chk("t6_busy", busy, 1'b1);
    for (int i = 7; i <= 15; i++) begin
      step();
      chk("run_outs", outs, expv(i));
      chk("run_done", done, 1'b0);
    end
    step();
    chk("t16_done", done, 1'b1);
    chk("t16_busy", busy, 1'b0);
    chk("t16_outs", outs, 4'b0010);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("post_done", done, 1'b0);
    chk("post_outs", outs, 4'b1111);
    chk("post_busy", busy, 1'b0);
    step();
    chk("norestart", busy, 1'b0);
    tick = 1'b0;

    // Tick every third cycle
    go();
    tick = 1'b0;
    n = 0;
    dcyc = 0;
    dcnt = 0;
    for (int c = 1; c <= 48; c++) begin
      tick = (c % 3 == 0);
      step();
      if (c % 3 == 0) n++;
      if (done) begin
        dcnt++;
        dcyc = c;
      end
      chk("gate_outs", outs, expv(n));
      chk("gate_busy", busy, (c < 48) ? 1'b1 : 1'b0);
    end
    tick = 1'b0;
    step();
    chk("gate_dcyc", dcyc, 48);
    chk("gate_dcnt", dcnt, 1);
    chk("gate_idle", outs, 4'b1111);
    chk("gate_ndone", done, 1'b0);

    // Abort at tick 5, then restart
    go();
    for (int i = 1; i <= 5; i++) step();
    chk("ab5_outs", outs, 4'b1011);
    stop = 1'b1;
    step();
    stop = 1'b0;
    chk("ab_outs", outs, 4'b1111);
    chk("ab_busy", busy, 1'b0);
    dcnt = 0;
    for (int i = 0; i < 4; i++) begin
      if (done) dcnt++;
      step();
    end
    chk("ab_nodone", dcnt, 0);
    go();
    chk("rs0_outs", outs, 4'b0000);
    chk("rs0_busy", busy, 1'b1);
    step();
    chk("rs1_outs", outs, 4'b1000);
    step();
    chk("rs2_outs", outs, 4'b0100);
    stop = 1'b1;
    step();
    stop = 1'b0;
    tick = 1'b0;

    // Async reset at tick 9
    go();
    for (int i = 1; i <= 9; i++) step();
    chk("ar9_outs", outs, 4'b1010);
    rst_n = 1'b0;
    #1;
    chk("ar_outs", outs, 4'b1111);
    chk("ar_busy", busy, 1'b0);
    chk("ar_done", done, 1'b0);
    step();
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) dcnt++;
    end
    chk("ar_nodone", dcnt, 0);
    chk("ar_idle", busy, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
